// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = A - B - bin, LSB first, one bit per clock through a registered borrow.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // One-bit full subtractor cell, returns {borrow_out, difference}.
    function automatic logic [1:0] sub_cell(input logic ai, input logic bi, input logic br);
        sub_cell = {(~ai & bi) | (~(ai ^ bi) & br), ai ^ bi ^ br};
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_br;
    logic             r_bout;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;
    logic [1:0]       w_cell;
    logic             w_d;
    logic             w_br_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    assign w_cell    = sub_cell(r_a[0], r_b[0], r_br);
    assign w_d       = w_cell[0];
    assign w_br_next = w_cell[1];

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign busy      = r_busy;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = r_ovf;
`endif

    // Control FSM, operand shifters, borrow chain and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_diff      <= {WIDTH{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_br        <= 1'b0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_br       <= bin;
                        r_cnt      <= {CNT_W{1'b0}};
                        r_diff     <= {WIDTH{1'b0}};
                        r_bout     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf      <= 1'b0;
`endif
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_a    <= {1'b0, r_a[WIDTH-1:1]};
                    r_b    <= {1'b0, r_b[WIDTH-1:1]};
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_br   <= w_br_next;
                    if (r_cnt == LAST_BIT) begin
                        // Shifter LSBs now hold the original operand MSBs.
                        r_cnt       <= {CNT_W{1'b0}};
                        r_bout      <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf       <= (r_a[0] ^ r_b[0]) & (r_a[0] ^ w_d);
`endif
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed plan cases plus random operands
// checked against an integer-arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_s;
    logic [W-1:0] b_s;
    logic         bin_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff_s;
    logic         bout_s;
    logic         busy_s;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf_s;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_s),
        .b         (b_s),
        .bin       (bin_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff_s),
        .bout      (bout_s),
        .busy      (busy_s)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf_s)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: {ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int u;
        int s;
        logic [W+1:0] r;
        u = int'(x) - int'(y) - int'(c);
        s = int'($signed(x)) - int'($signed(y)) - int'(c);
        r[W-1:0] = u[W-1:0];
        r[W]     = (u < 0);
        r[W+1]   = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
        return r;
    endfunction

    task automatic check_result(input string tag, input logic [W+1:0] r);
        check_eq({tag, "_diff"}, 32'(diff_s), 32'(r[W-1:0]));
        check_eq({tag, "_bout"}, 32'(bout_s), 32'(r[W]));
`ifdef SERIAL_SUB_OVF_EN
        check_eq({tag, "_ovf"}, 32'(ovf_s), 32'(r[W+1]));
`endif
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int hold);
        int k;
        logic [W+1:0] r;
        r = ref_sub(x, y, c);
        wait_ready();
        a_s = x; b_s = y; bin_s = c; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; a_s = W'($urandom); b_s = W'($urandom); bin_s = 1'($urandom);
        check_eq("busy_run", 32'(busy_s), 32'd1);
        check_eq("in_ready_run", 32'(in_ready), 32'd0);
        k = 0;
        while (out_valid !== 1'b1 && k < 4 * W) begin
            @(posedge clk); @(negedge clk);
            k++;
        end
        check_eq("latency", 32'(k), 32'(W));
        check_result("result", r);
        check_eq("busy_done", 32'(busy_s), 32'd0);
        check_eq("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            a_s = W'($urandom); b_s = W'($urandom);
            @(posedge clk); @(negedge clk);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
            check_result("hold", r);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("release_valid", 32'(out_valid), 32'd0);
        check_eq("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic reset_mid_run();
        int seen;
        wait_ready();
        a_s = 8'hFF; b_s = 8'h01; bin_s = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid_diff", 32'(diff_s), 32'd0);
        check_eq("rst_mid_busy", 32'(busy_s), 32'd0);
        check_eq("rst_mid_bout", 32'(bout_s), 32'd0);
        seen = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid === 1'b1 || busy_s === 1'b1) seen++;
        end
        check_eq("rst_mid_no_partial", 32'(seen), 32'd0);
        run_op(8'h10, 8'h01, 1'b0, 0);
    endtask

    task automatic back_to_back();
        logic [W-1:0] qa [3];
        logic [W-1:0] qb [3];
        logic         qc [3];
        logic [W+1:0] exp_q [$];
        logic [W+1:0] r;
        int idx, nres, last_t;
        logic acc;
        for (int i = 0; i < 3; i++) begin
            qa[i] = W'($urandom); qb[i] = W'($urandom); qc[i] = 1'($urandom);
        end
        wait_ready();
        idx = 0; nres = 0; last_t = 0;
        a_s = qa[0]; b_s = qb[0]; bin_s = qc[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 12 * (W + 2) && nres < 3; t++) begin
            acc = in_valid && in_ready;
            @(posedge clk); @(negedge clk);
            if (acc) begin
                exp_q.push_back(ref_sub(a_s, b_s, bin_s));
                idx++;
                if (idx < 3) begin
                    a_s = qa[idx]; b_s = qb[idx]; bin_s = qc[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                check_eq("b2b_pending", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    check_result("b2b", r);
                end
                if (nres > 0) check_eq("b2b_spacing", 32'(cyc - last_t), 32'(W + 2));
                last_t = cyc;
                nres++;
            end
        end
        in_valid = 1'b0;
        check_eq("b2b_count", 32'(nres), 32'd3);
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_s = '0; b_s = '0; bin_s = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_busy", 32'(busy_s), 32'd0);
        check_eq("rst_diff", 32'(diff_s), 32'd0);
        check_eq("rst_bout", 32'(bout_s), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check_eq("rst_ovf", 32'(ovf_s), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_op(8'h05, 8'h03, 1'b0, 0);
        run_op(8'h03, 8'h05, 1'b0, 0);
        run_op(8'h00, 8'h00, 1'b1, 0);
        run_op(8'hA5, 8'h5A, 1'b0, 5);
        reset_mid_run();
        back_to_back();
        run_op(8'h80, 8'h01, 1'b0, 0);
        run_op(8'h7F, 8'hFF, 1'b0, 0);
        run_op(8'h10, 8'h01, 1'b0, 0);
        run_op(8'h00, 8'hFF, 1'b1, 1);
        run_op(8'hFF, 8'hFF, 1'b1, 0);
        repeat (20) run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial full subtractor: computes A − B − bin over WIDTH bits, LSB first, one bit per clock, through a single registered borrow stage.
- Counterpart of the combinational full adder: reuses the same one-bit cell structure in the subtract direction.
- Used where area matters more than latency.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in, for chaining
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  A − B − bin, modulo 2^WIDTH
- bout  output  1  final borrow-out; 1 when unsigned A < B + bin
- busy  output  1  high in RUN state

Behaviour:
- Reset: synchronous, sampled on the clk rising edge while rst_n=0. Clears state to IDLE and clears the operand shift registers.
- Output values under reset: in_ready=0 during reset, then 1 on the first cycle after rst_n=1. out_valid=0, diff=0, bout=0, busy=0, bit counter=0, borrow register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a, b into shift registers; borrow register ← bin; counter ← 0; diff ← 0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, with ai = LSB of the A shift reg, bi = LSB of the B shift reg, br = borrow register:
    - d = ai ^ bi ^ br
    - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - d shifts into diff MSB (right shift), so after WIDTH cycles diff[0] holds bit 0.
  - A and B shift right by 1; counter increments.
  - When counter == WIDTH−1, the bit is processed and the state goes to DONE.
- DONE:
  - out_valid=1; bout = final borrow register.
  - diff and bout stay stable until out_ready=1.
  - On out_valid & out_ready: go to IDLE, out_valid ← 0.
  - No operand accept in the same cycle; the next accept is possible one cycle later.
- Latency: operand accepted at edge N → out_valid high from edge N+WIDTH. Throughput is one operation per WIDTH+2 cycles, assuming out_ready is held high.
- in_valid in RUN or DONE is ignored (in_ready=0). Operands a, b, bin are sampled only at accept.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted. The next cycle is IDLE with all outputs at reset values, and no partial result is ever presented.
- Arithmetic: unsigned modulo 2^WIDTH. diff = (a − b − bin) mod 2^WIDTH. bout = 1 exactly when a < b + bin, unsigned.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside bout and valid in DONE.
  - ovf = signed two's-complement overflow = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), using the latched operand MSBs. bin is included in diff.
  - ovf resets to 0.
- Undefined: port ovf is absent; no extra logic; all other behaviour is identical.

Test Plan (WIDTH=8):
1. Reset, then a=0x05, b=0x03, bin=0, out_ready=1 → out_valid exactly 8 cycles after the accept edge; diff=0x02, bout=0.
2. a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
3. Backpressure: a=0xA5, b=0x5A, out_ready=0 for 5 cycles after out_valid.
   - diff=0x4B, bout=0 held stable for all 5 cycles.
   - in_ready stays 0.
   - in_valid pulses during this window are ignored.
   - After out_ready=1: IDLE and in_ready=1 on the next cycle.
4. rst_n=0 for one cycle at the 4th RUN cycle of a=0xFF, b=0x01 → next cycle: state IDLE, out_valid=0, diff=0, busy=0. A fresh a=0x10, b=0x01 then yields diff=0x0F, bout=0.
5. Back-to-back: in_valid held high with a sequence of 3 operand pairs and out_ready=1 → 3 correct results, each spaced WIDTH+2 cycles apart, none dropped or duplicated.
6. With SERIAL_SUB_OVF_EN defined:
   - a=0x80, b=0x01 → diff=0x7F, ovf=1, bout=0.
   - a=0x7F, b=0xFF → diff=0x80, ovf=1, bout=1.
   - a=0x10, b=0x01 → ovf=0.
